// File: rtl/slot_pulse_decoder.sv
// slot_pulse_decoder: registered slot-index decoder for the dispenser drivers.
// Accepts a slot index over valid/ready, drives the matching one-hot output for
// PULSE_CYCLES cycles, then holds every output low for GAP_CYCLES cycles.
// At most one output bit is ever high.
//
// Build macro SLOT_PEND_EN: adds a one-entry pending request register so that a
// request offered during PULSE/GAP starts straight after the gap.
module slot_pulse_decoder #(
  parameter int unsigned SEL_W        = 4,
  parameter int unsigned NUM_OUTS     = 16,
  parameter int unsigned PULSE_CYCLES = 8,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  output logic                sel_ready,
  input  logic                abort,
  output logic [NUM_OUTS-1:0] onehot,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned CntMax = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYCLES);
  localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_CYCLES);
  localparam logic [CntW-1:0] CntLast   = CntW'(1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPulse = 2'd1,
    StGap   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_OUTS-1:0] onehot_q, onehot_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept;
  logic                in_range;

  // Pulse launch request raised by the next-state logic, applied in one place.
  logic                start_go;
  logic [SEL_W-1:0]    start_idx;

`ifdef SLOT_PEND_EN
  logic                pend_vld_q, pend_vld_d;
  logic [SEL_W-1:0]    pend_sel_q, pend_sel_d;
`endif

  // Index to one-hot; out-of-range codes never reach here but decode to zero anyway.
  function automatic logic [NUM_OUTS-1:0] decode(input logic [SEL_W-1:0] idx);
    logic [NUM_OUTS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_OUTS; i++) begin
      if (32'(idx) == i) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  // Ready: idle always; with the pending register also while busy and the slot is free.
  always_comb begin
`ifdef SLOT_PEND_EN
    sel_ready = ~reset & ((state_q == StIdle) | ~pend_vld_q);
`else
    sel_ready = ~reset & (state_q == StIdle);
`endif
  end

  assign accept   = sel_valid & sel_ready;
  assign in_range = 32'(sel) < NUM_OUTS;

  // Next-state: abort overrides everything below it, including a same-cycle accept.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    onehot_d  = onehot_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    start_go  = 1'b0;
    start_idx = sel;
`ifdef SLOT_PEND_EN
    pend_vld_d = pend_vld_q;
    pend_sel_d = pend_sel_q;
`endif

    if (abort) begin
      state_d  = StIdle;
      cnt_d    = '0;
      onehot_d = '0;
      busy_d   = 1'b0;
`ifdef SLOT_PEND_EN
      pend_vld_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (in_range) begin
              start_go  = 1'b1;
              start_idx = sel;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        StPulse: begin
          if (cnt_q == CntLast) begin
            state_d  = StGap;
            cnt_d    = GapLoad;
            onehot_d = '0;
            done_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
`ifdef SLOT_PEND_EN
          if (accept) begin
            if (in_range) begin
              pend_vld_d = 1'b1;
              pend_sel_d = sel;
            end else begin
              err_d = 1'b1;
            end
          end
`endif
        end

        StGap: begin
          if (cnt_q == CntLast) begin
`ifdef SLOT_PEND_EN
            // Chain straight into the next pulse; a request arriving on the last gap
            // cycle with an empty slot is launched directly instead of being parked.
            if (pend_vld_q) begin
              start_go   = 1'b1;
              start_idx  = pend_sel_q;
              pend_vld_d = 1'b0;
            end else if (accept && in_range) begin
              start_go  = 1'b1;
              start_idx = sel;
            end else begin
              state_d = StIdle;
              cnt_d   = '0;
              busy_d  = 1'b0;
            end
            if (accept && !in_range) begin
              err_d = 1'b1;
            end
`else
            state_d = StIdle;
            cnt_d   = '0;
            busy_d  = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q - 1'b1;
`ifdef SLOT_PEND_EN
            if (accept) begin
              if (in_range) begin
                pend_vld_d = 1'b1;
                pend_sel_d = sel;
              end else begin
                err_d = 1'b1;
              end
            end
`endif
          end
        end

        default: begin
          state_d  = StIdle;
          cnt_d    = '0;
          onehot_d = '0;
          busy_d   = 1'b0;
        end
      endcase

      if (start_go) begin
        state_d  = StPulse;
        cnt_d    = PulseLoad;
        onehot_d = decode(start_idx);
        busy_d   = 1'b1;
      end
    end
  end

  // Main state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      onehot_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef SLOT_PEND_EN
  // Pending request register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld_q <= 1'b0;
      pend_sel_q <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_sel_q <= pend_sel_d;
    end
  end
`else
`endif

  assign onehot = onehot_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

  // Solenoid safety: never two drivers at once, and never a driver outside busy.
  a_onehot0 : assert property (@(posedge clk) $onehot0(onehot_q));
  a_busy_cover : assert property (@(posedge clk) (onehot_q != '0) |-> busy_q);

endmodule

// File: tb/tb_slot_pulse_decoder.sv
// Bench for slot_pulse_decoder: a vector table, hand-written corner sequences and a
// randomized run against a schedule-based reference model. Two instances: the default
// 16-output build and a 12-output build that exercises out-of-range codes.
module tb_slot_pulse_decoder;

  localparam int P = 8;
  localparam int G = 2;
`ifdef SLOT_PEND_EN
  localparam bit PendEn = 1'b1;
`else
  localparam bit PendEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sel_valid, abort, sel_ready, busy, done, err;
  logic [3:0]  sel;
  logic [15:0] onehot;
  logic        sel_valid12, abort12, sel_ready12, busy12, done12, err12;
  logic [3:0]  sel12;
  logic [11:0] onehot12;

  int checks = 0;
  int failures = 0;
  int first_rdy, done_cnt, done_at;

  always #5 clk = ~clk;

  slot_pulse_decoder #(
    .SEL_W(4), .NUM_OUTS(16), .PULSE_CYCLES(P), .GAP_CYCLES(G)
  ) dut (
    .clk(clk), .reset(reset), .sel_valid(sel_valid), .sel(sel), .sel_ready(sel_ready),
    .abort(abort), .onehot(onehot), .busy(busy), .done(done), .err(err)
  );

  slot_pulse_decoder #(
    .SEL_W(4), .NUM_OUTS(12), .PULSE_CYCLES(P), .GAP_CYCLES(G)
  ) dut12 (
    .clk(clk), .reset(reset), .sel_valid(sel_valid12), .sel(sel12), .sel_ready(sel_ready12),
    .abort(abort12), .onehot(onehot12), .busy(busy12), .done(done12), .err(err12)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // One cycle on the 16-output instance; inputs change after negedge, sampled 1 ns later.
  task automatic drive(input bit r, input bit v, input logic [3:0] s, input bit a);
    @(negedge clk);
    reset = r; sel_valid = v; sel = s; abort = a;
    sel_valid12 = 1'b0; sel12 = 4'd0; abort12 = 1'b0;
    #1;
  endtask

  task automatic drive12(input bit v, input logic [3:0] s, input bit a);
    @(negedge clk);
    reset = 1'b0; sel_valid = 1'b0; sel = 4'd0; abort = 1'b0;
    sel_valid12 = v; sel12 = s; abort12 = a;
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    bit          vld;
    logic [3:0]  sel;
    bit          abt;
    bit          chk;
    logic [15:0] oh;
    bit          bsy;
    bit          dn;
    bit          er;
    bit          rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit v, logic [3:0] s, bit a, bit c,
                              logic [15:0] oh, bit b, bit d, bit e, bit rd);
    vec_t x;
    x.rst = r; x.vld = v; x.sel = s; x.abt = a; x.chk = c;
    x.oh = oh; x.bsy = b; x.dn = d; x.er = e; x.rdy = rd;
    return x;
  endfunction

  // ---------------- reference model ----------------
  // A request is a schedule: pulse on [start, start+P), busy on [start, start+P+G),
  // done at start+P. A request taken while busy starts at the previous start+P+G.
  typedef struct {
    bit act;
    int slot;
    int start;
    bit pv;
    int pslot;
    int pstart;
    int err_cyc;
  } mdl_t;

  function automatic mdl_t mdl_advance(mdl_t m, int c);
    if (m.act && c >= m.start + P + G) m.act = 1'b0;
    if (m.pv && c == m.pstart) begin
      m.act = 1'b1; m.slot = m.pslot; m.start = m.pstart; m.pv = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [31:0] m_onehot(mdl_t m, int c);
    return (m.act && c < m.start + P) ? (32'd1 << m.slot) : 32'd0;
  endfunction

  function automatic bit m_ready(mdl_t m, bit r);
    return !r && (!m.act || (PendEn && !m.pv));
  endfunction

  function automatic mdl_t mdl_update(mdl_t m, int c, bit r, bit v, int s, bit a, int n,
                                      bit rdy);
    if (r) begin
      m.act = 1'b0; m.pv = 1'b0; m.err_cyc = -1;
    end else if (a) begin
      m.act = 1'b0; m.pv = 1'b0;
    end else if (v && rdy) begin
      if (s >= n) m.err_cyc = c + 1;
      else if (!m.act) begin
        m.act = 1'b1; m.slot = s; m.start = c + 1;
      end else begin
        m.pv = 1'b1; m.pslot = s; m.pstart = m.start + P + G;
      end
    end
    return m;
  endfunction

  mdl_t m0, m1;

  task automatic cmp_model(input string tag, input int c, input mdl_t m, input logic [31:0] oh,
                           input logic b, input logic d, input logic e, input logic rd,
                           input bit r);
    check($sformatf("%s c%0d onehot", tag, c), oh, m_onehot(m, c));
    check($sformatf("%s c%0d busy", tag, c), 32'(b), 32'(m.act));
    check($sformatf("%s c%0d done", tag, c), 32'(d), 32'(m.act && c == m.start + P));
    check($sformatf("%s c%0d err", tag, c), 32'(e), 32'(m.err_cyc == c));
    check($sformatf("%s c%0d ready", tag, c), 32'(rd), 32'(m_ready(m, r)));
  endtask

  initial begin
    reset = 1'b1; sel_valid = 1'b0; sel = 4'd0; abort = 1'b0;
    sel_valid12 = 1'b0; sel12 = 4'd0; abort12 = 1'b0;

    // Reset for 3 cycles, slot 5 pulse, gap, idle, then abort colliding with an accept.
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < P; i++)
      vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 4'd6, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].sel, vecs[i].abt);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d onehot", i), 32'(onehot), 32'(vecs[i].oh));
        check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
        check($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].dn));
        check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].er));
        check($sformatf("vec%0d ready", i), 32'(sel_ready), 32'(vecs[i].rdy));
      end
    end

    // Out-of-range on the 12-output build: 13 and boundary 12 error, 11 pulses.
    drive12(1'b1, 4'd13, 1'b0);
    check("n12 ready before 13", 32'(sel_ready12), 32'd1);
    drive12(1'b0, 4'd0, 1'b0);
    check("n12 err after 13", 32'(err12), 32'd1);
    check("n12 onehot after 13", 32'(onehot12), 32'd0);
    check("n12 busy after 13", 32'(busy12), 32'd0);
    check("n12 ready after 13", 32'(sel_ready12), 32'd1);
    drive12(1'b1, 4'd11, 1'b0);
    check("n12 err one cycle", 32'(err12), 32'd0);
    drive12(1'b0, 4'd0, 1'b0);
    check("n12 onehot slot 11", 32'(onehot12), 32'h800);
    drive12(1'b0, 4'd0, 1'b1);
    drive12(1'b1, 4'd12, 1'b0);
    check("n12 busy after abort", 32'(busy12), 32'd0);
    drive12(1'b0, 4'd0, 1'b0);
    check("n12 err after 12", 32'(err12), 32'd1);
    check("n12 onehot after 12", 32'(onehot12), 32'd0);

    // Abort on the 4th pulse cycle, then slot 15 accepted immediately; no stale done.
    drive(1'b0, 1'b1, 4'd0, 1'b0);
    check("abort ready", 32'(sel_ready), 32'd1);
    for (int j = 1; j <= 3; j++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b0);
      check($sformatf("abort pulse%0d", j), 32'(onehot), 32'h1);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    check("abort pulse4", 32'(onehot), 32'h1);
    drive(1'b0, 1'b1, 4'd15, 1'b0);
    check("abort onehot cleared", 32'(onehot), 32'd0);
    check("abort busy cleared", 32'(busy), 32'd0);
    check("abort ready again", 32'(sel_ready), 32'd1);
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    check("abort slot15", 32'(onehot), 32'h8000);
    done_cnt = 0; done_at = -1;
    for (int j = 7; j <= 16; j++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b0);
      if (done === 1'b1) begin
        done_cnt++; done_at = j;
      end
    end
    check("abort done count", 32'(done_cnt), 32'd1);
    check("abort done cycle", 32'(done_at), 32'd14);
    check("abort back idle", 32'(busy), 32'd0);

    // Valid held: slot 3 then slot 7; second accept exactly P+G+1 cycles later.
    drive(1'b0, 1'b1, 4'd3, 1'b0);
    first_rdy = -1;
    for (int j = 1; j <= 11; j++) begin
      drive(1'b0, 1'b1, 4'd7, 1'b0);
      check($sformatf("hold onehot0 %0d", j), 32'($onehot0(onehot)), 32'd1);
      if (sel_ready === 1'b1 && first_rdy < 0) first_rdy = j;
    end
    check("hold accept spacing", 32'(first_rdy), 32'd11);
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    check("hold slot7", 32'(onehot), 32'h80);
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    check("hold abort idle", 32'(busy), 32'd0);

`ifdef SLOT_PEND_EN
    // Pending: slot 9 offered during the slot 2 pulse chains in with no idle cycle.
    drive(1'b0, 1'b1, 4'd2, 1'b0);
    for (int j = 1; j <= 21; j++) begin
      drive(1'b0, (j == 2), (j == 2) ? 4'd9 : 4'd0, 1'b0);
      if (j == 2) check("pend ready busy", 32'(sel_ready), 32'd1);
      check($sformatf("pend onehot %0d", j), 32'(onehot),
            (j <= 8) ? 32'h4 : (j <= 10) ? 32'h0 : (j <= 18) ? 32'h200 : 32'h0);
      check($sformatf("pend busy %0d", j), 32'(busy), 32'(j <= 20));
    end
`endif

    // Randomized run of both instances against the schedule model.
    m0 = '{default: 0}; m1 = '{default: 0};
    m0.err_cyc = -1; m1.err_cyc = -1;
    for (int c = 0; c < 800; c++) begin
      bit r, v0, a0, v1, a1;
      logic [3:0] s0, s1;
      r  = (c == 0) || ($urandom_range(149) == 0);
      v0 = ($urandom_range(2) == 0);
      v1 = ($urandom_range(2) == 0);
      a0 = ($urandom_range(29) == 0);
      a1 = ($urandom_range(29) == 0);
      s0 = 4'($urandom_range(15));
      s1 = 4'($urandom_range(15));
      @(negedge clk);
      reset = r; sel_valid = v0; sel = s0; abort = a0;
      sel_valid12 = v1; sel12 = s1; abort12 = a1;
      #1;
      m0 = mdl_advance(m0, c);
      m1 = mdl_advance(m1, c);
      if (c > 0) begin
        cmp_model("rnd16", c, m0, 32'(onehot), busy, done, err, sel_ready, r);
        cmp_model("rnd12", c, m1, 32'(onehot12), busy12, done12, err12, sel_ready12, r);
      end
      m0 = mdl_update(m0, c, r, v0, int'(s0), a0, 16, m_ready(m0, r));
      m1 = mdl_update(m1, c, r, v1, int'(s1), a1, 12, m_ready(m1, r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
